// File: rtl/fwd_scoreboard.sv
// D-stage forwarding scoreboard: tracks in-flight producers with per-stage Tnew countdowns,
// resolves per-port bypass selects and the D stall, and owns the mult/div busy counter.
// Optional macro FWD_STATS_EN adds wrapping stall/forward-hit counters.
module fwd_scoreboard #(
  parameter int AW     = 5,
  parameter int DEPTH  = 3,
  parameter int NRD    = 3,
  parameter int TW     = 2,
  parameter int SW     = 2,
  parameter int MD_LAT = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              id_we,
  input  logic [AW-1:0]     id_wa,
  input  logic [TW-1:0]     id_tnew,
  input  logic              id_md_use,
  input  logic              md_start,
  input  logic [NRD-1:0]    rd_use,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD*TW-1:0] rd_tuse,
  output logic [NRD*SW-1:0] fwd_sel,
  output logic              stall,
  output logic              md_busy,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_fwd
);

  localparam int MCW = $clog2(MD_LAT + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [AW-1:0]    dst_q  [DEPTH];
  logic [AW-1:0]    dst_d  [DEPTH];
  logic [TW-1:0]    tnew_q [DEPTH];
  logic [TW-1:0]    tnew_d [DEPTH];
  logic [MCW-1:0]   md_cnt_q, md_cnt_d;
  logic [NRD-1:0]   port_stall;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin : fwd_resolve
    logic          hit;
    logic [TW-1:0] hit_tnew;
    logic [SW-1:0] hit_sel;
    logic [AW-1:0] addr;
    logic [TW-1:0] tuse;
    fwd_sel    = '0;
    port_stall = '0;
    for (int p = 0; p < NRD; p++) begin
      addr     = rd_addr[p*AW +: AW];
      tuse     = rd_tuse[p*TW +: TW];
      hit      = 1'b0;
      hit_tnew = '0;
      hit_sel  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (v_q[i] && (dst_q[i] == addr)) begin
          hit      = 1'b1;
          hit_tnew = tnew_q[i];
          hit_sel  = SW'(i + 1);
        end
      end
      if (rd_use[p] && (addr != '0) && hit) begin
        if (hit_tnew == '0) begin
          fwd_sel[p*SW +: SW] = hit_sel;
        end else if (hit_tnew > tuse) begin
          port_stall[p] = 1'b1;
        end
      end
    end
  end

  assign md_busy = (md_cnt_q != '0);
  assign stall   = (|port_stall) || (id_md_use && (md_busy || md_start));

  always_comb begin
    v_d[0]    = id_we && (id_wa != '0) && !stall;
    dst_d[0]  = id_wa;
    tnew_d[0] = id_tnew;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]    = v_q[i-1];
      dst_d[i]  = dst_q[i-1];
      tnew_d[i] = (tnew_q[i-1] != '0) ? tnew_q[i-1] - TW'(1) : '0;
    end
    if (flush) begin
      v_d = '0;
    end
    if (md_start) begin
      md_cnt_d = MCW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MCW'(1);
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q      <= '0;
      md_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= '0;
        tnew_q[i] <= '0;
      end
    end else begin
      v_q      <= v_d;
      md_cnt_q <= md_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= dst_d[i];
        tnew_q[i] <= tnew_d[i];
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stat_stall_q, stat_fwd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_stall_q <= '0;
      stat_fwd_q   <= '0;
    end else begin
      if (stall) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
      if (|fwd_sel) begin
        stat_fwd_q <= stat_fwd_q + 32'd1;
      end
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_fwd   = stat_fwd_q;
`else
  assign stat_stall = '0;
  assign stat_fwd   = '0;
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the combinational stage-compare forwarding selector.
- Tracks in-flight register producers with a registered Tnew countdown per pipeline stage.
- Serves NRD decode-stage read ports, producing per-port forward selects and a single D-stage stall.
- Also owns the mult/div busy counter. Sits beside the decoder; drives the D-stage bypass muxes and the F/D enable and E bubble.

Parameters:
- AW, 5, register address width (2^AW registers; address 0 hardwired zero).
- DEPTH, 3, tracked producer stages after D (entry 0=E, 1=M, 2=W).
- NRD, 3, number of D-stage read ports.
- TW, 2, width of Tnew/Tuse fields.
- SW, 2, forward select width; must satisfy 2^SW > DEPTH.
- MD_LAT, 5, mult/div busy cycles after start.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  exception/eret flush; clears all entries
- id_we  in  1  D instruction writes GPR
- id_wa  in  AW  D instruction destination
- id_tnew  in  TW  cycles until result, counted from entry into E (0 = ready in E)
- id_md_use  in  1  D instruction is mult/div/mf/mt HI/LO
- md_start  in  1  mult/div in E starts this cycle
- rd_use  in  NRD  port p reads a register
- rd_addr  in  NRD*AW  port p address, port p at bits [p*AW +: AW]
- rd_tuse  in  NRD*TW  cycles until port p value is consumed
- fwd_sel  out  NRD*SW  0 = regfile, k = forward from entry k-1
- stall  out  1  freeze F/D, bubble into E
- md_busy  out  1  mult/div counter nonzero
- stat_stall  out  32  stall cycle count (optional feature)
- stat_fwd  out  32  forwarding-hit count (optional feature)

Behaviour:
- Entry fields: {v, dst[AW], tnew[TW]}. Reset: all v=0, dst=0, tnew=0; md counter 0; stat counters 0; outputs then resolve to fwd_sel=0, stall=0, md_busy=0.
- Every rising clk:
  - entry[i+1] <= entry[i], with tnew decremented and saturating at 0. The last entry is dropped; the regfile is write-through.
  - entry[0] <= {id_we && id_wa!=0 && !stall, id_wa, id_tnew}.
  - A stalled cycle inserts a bubble (v=0) into entry 0.
- flush overrides the shift: all v <= 0 next cycle. Flush has priority over stall and over new issue.
- Per port p, combinational, when rd_use[p] && rd_addr[p]!=0:
  - Match = the lowest-index (youngest) valid entry with dst==rd_addr[p]. Older matches are ignored.
  - No match: fwd_sel=0, no stall contribution.
  - Match i with tnew==0: fwd_sel=i+1.
  - Match i with tnew>rd_tuse[p]: stall contribution, fwd_sel=0.
  - Match i with 0<tnew<=rd_tuse[p]: fwd_sel=0, no stall; a downstream stage picks the value up later.
- rd_use=0 or address 0: fwd_sel=0, never stall.
- Mult/div counter:
  - md_start loads MD_LAT; otherwise decrements while nonzero.
  - md_busy = (counter != 0).
  - md_start while already busy reloads MD_LAT.
  - Unaffected by flush.
- stall = OR of port stall contributions, OR (id_md_use && (md_busy || md_start)).
- reset_n low mid-operation clears all state immediately, asynchronously.

Optional Feature:
- Macro FWD_STATS_EN. When defined, two 32-bit wrapping counters exist:
  - stat_stall increments each cycle stall=1.
  - stat_fwd increments each cycle at least one port has fwd_sel!=0.
  - Both are cleared only by reset, not by flush.
- When undefined, no counter registers exist and both outputs are tied to 0.

Test Plan:
- Issue addu $8 (tnew=1). Next cycle port0 reads $8 with tuse=0 -> stall=1 for 1 cycle. Following cycle fwd_sel[0]=2 (entry M), stall=0.
- Issue jal ($31, tnew=0). Next cycle port1 reads $31 with tuse=0 -> fwd_sel[1]=1, stall=0.
- lw $5 (tnew=2) then addu $5 (tnew=1) back-to-back. A reader of $5 with tuse=1 sees the youngest (addu) entry: no stall, fwd_sel=0 first cycle; the lw entry is ignored.
- Read of $0 while a producer targets $0 -> producer not tracked (v=0), fwd_sel=0, stall=0.
- md_start, then D holds mflo with id_md_use=1 -> stall asserted 5 cycles (MD_LAT=5) plus the start cycle. md_busy falls after 5 cycles.
- lw $9 in flight, flush=1 -> next cycle all entries invalid: reader of $9 gets fwd_sel=0, stall=0. With FWD_STATS_EN, stat_stall unchanged by the flush.
